pc_fetch_ctrl: RTL

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/cpu_pkg.sv | 16 +
 rtl/pc_fetch_ctrl.sv | 99 +++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM encoding and datapath defaults.
package cpu_pkg;

    localparam int unsigned PC_W       = 5;
    localparam int unsigned INST_W_DEF = 16;

    localparam logic [PC_W-1:0] RESET_PC_DEF = 5'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, issues memory reads, hands one
// registered instruction at a time to decode, and handles redirects and halt.
module pc_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned     INST_W   = INST_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   IPC,
    output logic [PC_W-1:0]   PC,
    input  logic              br_take,
    input  logic [PC_W-1:0]   br_target,
    input  logic              halt,
    output logic              imem_req,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    input  logic              inst_ready
);

    fetch_state_t      state;
    fetch_state_t      state_n;
    logic [PC_W-1:0]   pc_n;
    logic [INST_W-1:0] inst_n;
    logic              inst_valid_n;
    logic              redirect_pend;
    logic              redirect_pend_n;

    // Memory request is a pure decode of the fetch state.
    assign imem_req = (state == REQ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            PC            <= RESET_PC;
            inst          <= '0;
            inst_valid    <= 1'b0;
            redirect_pend <= 1'b0;
        end else begin
            state         <= state_n;
            PC            <= pc_n;
            inst          <= inst_n;
            inst_valid    <= inst_valid_n;
            redirect_pend <= redirect_pend_n;
        end
    end

    always_comb begin
        state_n         = state;
        pc_n            = PC;
        inst_n          = inst;
        inst_valid_n    = inst_valid;
        redirect_pend_n = redirect_pend;

        case (state)
            IDLE: begin
                state_n = halt ? HALT : REQ;
            end

            REQ: begin
                if (imem_ack) begin
                    // Data for a redirected-away address is dropped; re-fetch at the target.
                    if (redirect_pend || br_take) begin
                        redirect_pend_n = 1'b0;
                        if (br_take) begin
                            pc_n = br_target;
                        end
                    end else begin
                        inst_n       = imem_rdata;
                        inst_valid_n = 1'b1;
                        state_n      = HOLD;
                    end
                end else if (br_take) begin
                    redirect_pend_n = 1'b1;
                    pc_n            = br_target;
                end
            end

            HOLD: begin
                if (inst_ready) begin
                    inst_valid_n = 1'b0;
                    pc_n         = br_take ? br_target : IPC;
                    state_n      = halt ? HALT : REQ;
                end
            end

            HALT: begin
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
